// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: per-channel reset conditioning with synchronised,
// stretched release and an ordered, gapped release of all channels after a
// global reset. A bypass mode routes the raw global request to every channel.
module rst_seq_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_W   = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETN,
  input  logic                 glob_req,
  input  logic [NUM_CH-1:0]    rst_req,
  input  logic                 bypass,
  input  logic [STRETCH_W-1:0] stretch_len,
  output logic [NUM_CH-1:0]    chan_rst,
  output logic                 seq_busy,
  output logic                 seq_done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  logic [NUM_CH-1:0]                     req;
  logic [NUM_CH-1:0]                     tail;
  logic [NUM_CH-1:0]                     cnt_nz;
  logic                                  gtail;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0]    sync_q, sync_d;
  logic [SYNC_STAGES-1:0]                gsync_q, gsync_d;
  logic [NUM_CH-1:0][STRETCH_W-1:0]      cnt_q, cnt_d;
  logic [STRETCH_W-1:0]                  gcnt_q, gcnt_d;

  state_t                                state_q, state_d;
  logic [NUM_CH-1:0]                     hold_q, hold_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [GAP_W-1:0]                      gap_q, gap_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;

  assign req   = rst_req | {NUM_CH{glob_req}};
  assign tail  = sync_q[SYNC_STAGES-1];
  assign gtail = gsync_q[SYNC_STAGES-1];

  // Shift requests through the synchronisers and run the stretch counters (load wins over decrement)
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req};
    gsync_d = {gsync_q[SYNC_STAGES-2:0], glob_req};
    cnt_nz  = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nz[i] = (cnt_q[i] != '0);
      if (tail[i]) begin
        cnt_d[i] = stretch_len;
      end else if (cnt_nz[i]) begin
        cnt_d[i] = cnt_q[i] - STRETCH_W'(1);
      end
    end
    if (gtail) begin
      gcnt_d = stretch_len;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - STRETCH_W'(1);
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  // Synchroniser and counter registers; reset makes every request look freshly asserted
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      sync_q  <= '1;
      gsync_q <= '1;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      gsync_q <= gsync_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Sequencer next state: hold all channels, then release them one at a time, restart on a new global request
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        hold_d = '0;
        if (gtail) begin
          state_d = S_HOLD;
          hold_d  = '1;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      S_HOLD: begin
        hold_d = '1;
        if (!gtail && (gcnt_q == '0)) begin
          state_d = S_RELEASE;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      S_RELEASE: begin
        if (gtail) begin
          state_d = S_HOLD;
          hold_d  = '1;
          idx_d   = '0;
          gap_d   = '0;
        end else if (gap_q == '0) begin
          hold_d[idx_q] = 1'b0;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            gap_d = GAP_W'(GAP_CYCLES - 1);
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        if (gtail) begin
          state_d = S_HOLD;
          hold_d  = '1;
          idx_d   = '0;
          gap_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_HOLD;
        hold_d  = '1;
        idx_d   = '0;
        gap_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer registers including the registered busy/done decodes; reset parks it in HOLD
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q <= S_HOLD;
      hold_q  <= '1;
      idx_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign chan_rst = bypass ? {NUM_CH{glob_req}} : (req | tail | cnt_nz | hold_q);
  assign seq_busy = busy_q;
  assign seq_done = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl. The driver records every cycle's inputs and
// pushes the reference model's expectation; a negedge monitor pops and compares.
// The model works from request history: a channel is held while its request is
// live or its last synchronised request is within the stretch window, and the
// sequencer schedule is derived from the end of the latest global request burst.
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int G    = 4;
  localparam int W    = 8;
  localparam int MAXC = 4096;

  typedef struct {
    int           cyc;
    bit           chk;
    logic [N-1:0] chan;
    bit           busy;
    bit           done;
  } exp_t;

  logic         HCLK = 1'b0;
  logic         HRESETN;
  logic         glob_req;
  logic [N-1:0] rst_req;
  logic         bypass;
  logic [W-1:0] stretch_len;
  logic [N-1:0] chan_rst;
  logic         seq_busy;
  logic         seq_done;

  bit           glob_h    [MAXC];
  bit           glob_in_h [MAXC];
  logic [N-1:0] req_h     [MAXC];
  int           len_h     [MAXC];
  bit           rstn_h    [MAXC];
  bit           byp_h     [MAXC];

  exp_t sb[$];
  int   cur     = 0;
  int   cur_len = 3;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  rst_seq_ctrl #(
    .NUM_CH     (N),
    .SYNC_STAGES(S),
    .STRETCH_W  (W),
    .GAP_CYCLES (G)
  ) dut (
    .HCLK       (HCLK),
    .HRESETN    (HRESETN),
    .glob_req   (glob_req),
    .rst_req    (rst_req),
    .bypass     (bypass),
    .stretch_len(stretch_len),
    .chan_rst   (chan_rst),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done)
  );

  // Free-running block clock
  always #5 HCLK = ~HCLK;

  // Expected outputs for cycle c, from the recorded request history
  function automatic exp_t model(int c);
    exp_t         e;
    logic [N-1:0] hold;
    int           q, j, ge, e_edge;
    bit           hit;
    e.cyc  = c;
    e.chk  = 1'b1;
    e.chan = '0;
    e.busy = 1'b0;
    e.done = 1'b0;
    hold   = '0;
    if (!rstn_h[c]) begin
      if (c == 0 || rstn_h[c-1]) begin
        e.chk = 1'b0;
      end else begin
        e.chan = byp_h[c] ? {N{glob_in_h[c]}} : {N{1'b1}};
        e.busy = 1'b1;
      end
      return e;
    end
    q = c - S - 1;
    j = -1;
    for (int d = 0; d < 400; d++) begin
      if (q - d < 0) break;
      if (glob_h[q-d]) begin
        j = q - d;
        break;
      end
    end
    if (j >= 0) begin
      ge = j;
      while (ge < c && glob_h[ge+1]) ge++;
      if (ge + S > c) begin
        hold   = '1;
        e.busy = 1'b1;
      end else begin
        e_edge = ge + S + len_h[ge+S] + 2;
        for (int k = 0; k < N; k++) hold[k] = (c <= e_edge + k * G);
        e.busy = (c <= e_edge + 1 + (N - 1) * G);
        e.done = (c == e_edge + 1 + (N - 1) * G);
      end
    end
    for (int i = 0; i < N; i++) begin
      hit = 1'b0;
      for (int d = 0; d <= 300; d++) begin
        if (c - d - S < 0) break;
        if (req_h[c-d-S][i]) begin
          hit = (d <= len_h[c-d]);
          break;
        end
      end
      e.chan[i] = byp_h[c] ? glob_in_h[c] : (req_h[c][i] | hit | hold[i]);
    end
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge, log them, and queue the expectation
  task automatic applyStimulus(input bit rstn, input bit glob, input logic [N-1:0] req, input bit byp);
    @(posedge HCLK);
    #1;
    HRESETN     = rstn;
    glob_req    = glob;
    rst_req     = req;
    bypass      = byp;
    stretch_len = W'(cur_len);
    if (cur >= MAXC) begin
      $display("[TB] FAIL history: cycle %0d exceeds capacity %0d", cur, MAXC);
      $fatal(1, "[TB] history overflow");
    end
    rstn_h[cur]    = rstn;
    byp_h[cur]     = byp;
    glob_in_h[cur] = glob;
    len_h[cur]     = cur_len;
    if (!rstn) begin
      glob_h[cur] = 1'b1;
      req_h[cur]  = '1;
    end else begin
      glob_h[cur] = glob;
      req_h[cur]  = req | {N{glob}};
    end
    sb.push_back(model(cur));
    cur++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Compare the DUT against one popped expectation
  task automatic checkOutput(input exp_t e);
    if (!e.chk) return;
    n_cmp++;
    if (chan_rst !== e.chan) begin
      n_bad++;
      $display("[TB] FAIL chan_rst cycle %0d: got %b, expected %b", e.cyc, chan_rst, e.chan);
    end
    n_cmp++;
    if (seq_busy !== e.busy) begin
      n_bad++;
      $display("[TB] FAIL seq_busy cycle %0d: got %b, expected %b", e.cyc, seq_busy, e.busy);
    end
    n_cmp++;
    if (seq_done !== e.done) begin
      n_bad++;
      $display("[TB] FAIL seq_done cycle %0d: got %b, expected %b", e.cyc, seq_done, e.done);
    end
  endtask

  // Monitor: consume expectations on the falling edge, away from the active edge
  always @(negedge HCLK) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // Stimulus sequence
  initial begin
    int burst_left;
    logic [N-1:0] rq;
    bit g;
    HRESETN     = 1'b0;
    glob_req    = 1'b0;
    rst_req     = '0;
    bypass      = 1'b0;
    stretch_len = W'(3);
    burst_left  = 0;

    $display("[TB] reset release sequence");
    cur_len = 3;
    repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    idle(30);

    $display("[TB] soft request on channel 2");
    applyStimulus(1'b1, 1'b0, 4'b0100, 1'b0);
    idle(15);

    $display("[TB] randomized requests");
    for (int n = 0; n < 500; n++) begin
      if (burst_left > 0) begin
        g = 1'b1;
        burst_left--;
      end else if ($urandom_range(0, 49) == 0) begin
        g = 1'b1;
        burst_left = $urandom_range(0, 3);
      end else begin
        g = 1'b0;
      end
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 15) == 0);
      applyStimulus(1'b1, g, rq, 1'b0);
    end
    idle(40);

    $display("[TB] re-trigger during release");
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    idle(10);
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    idle(40);

    $display("[TB] bypass mode");
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
    idle(40);

    $display("[TB] zero stretch");
    cur_len = 0;
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    idle(40);

    $display("[TB] maximum stretch");
    cur_len = 255;
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    idle(300);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0);
    idle(300);

    $display("[TB] reset in the middle of release");
    cur_len = 3;
    applyStimulus(1'b1, 1'b1, '0, 1'b0);
    idle(10);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    idle(40);

    @(negedge HCLK);
    @(negedge HCLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cur);
    $fatal(1, "[TB] timeout");
  end

endmodule
